// File: rtl/booth_csa_row_stage_pkg.sv
// Shared Booth radix-4 definitions for the multiplier row stages.
package booth_pkg;

  localparam int BOOTH_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG2,
    BD_NEG1
  } booth_digit_t;

  // Map a multiplier bit triplet {b[2i+1], b[2i], b[2i-1]} to its Booth digit.
  function automatic booth_digit_t booth_decode(input logic [2:0] trip);
    booth_digit_t d;
    case (trip)
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_csa_row_stage_pp_gen.sv
// Booth digit decode and partial-product generation for one row (combinational).
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH     = BOOTH_WIDTH_DEF,
  parameter int PW        = 2*WIDTH,
  parameter int STAGE_IDX = 0
) (
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [PW-1:0]    pp,
  output logic             neg
);

  localparam int SH = 2*STAGE_IDX;

  logic [WIDTH:0]   mplier_ext;
  logic [2:0]       trip;
  booth_digit_t     digit;
  logic [WIDTH:0]   m1;
  logic [WIDTH:0]   m2;
  logic [PW-1:0]    m1_ext;
  logic [PW-1:0]    m2_ext;

  // Implicit mplier[-1] = 0 appended below the LSB.
  assign mplier_ext = {mplier, 1'b0};
  assign trip       = mplier_ext[SH +: 3];
  assign digit      = booth_decode(trip);

  // M and 2M at WIDTH+1 bits, then sign-extended to the accumulation width.
  assign m1     = {mcand[WIDTH-1], mcand};
  assign m2     = {mcand, 1'b0};
  assign m1_ext = {{(PW-WIDTH-1){m1[WIDTH]}}, m1};
  assign m2_ext = {{(PW-WIDTH-1){m2[WIDTH]}}, m2};

  // Negative digits invert before shifting so the +1 lands exactly at bit 2i.
  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (digit)
      BD_POS1: pp = m1_ext << SH;
      BD_POS2: pp = m2_ext << SH;
      BD_NEG1: begin
        pp  = (~m1_ext) << SH;
        neg = 1'b1;
      end
      BD_NEG2: begin
        pp  = (~m2_ext) << SH;
        neg = 1'b1;
      end
      default: begin
        pp  = '0;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fulladder.sv
// 3:2 compressor cell used per bit of the carry-save row.
module fulladder (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic sum,
  output logic carry
);

  assign sum   = in0 ^ in1 ^ in2;
  assign carry = (in0 & in1) | (in0 & in2) | (in1 & in2);

endmodule

// File: rtl/booth_csa_row_stage.sv
// One registered row of the radix-4 Booth carry-save multiplier array.
// Optional macro BOOTH_SKID_EN selects a 2-entry skid buffer with a registered
// in_ready; otherwise a single output register with combinational in_ready.
module booth_csa_row_stage
  import booth_pkg::*;
#(
  parameter int WIDTH     = BOOTH_WIDTH_DEF,
  parameter int PW        = 2*WIDTH,
  parameter int STAGE_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mcand,
  input  logic [WIDTH-1:0] in_mplier,
  input  logic [PW-1:0]    in_sum,
  input  logic [PW-1:0]    in_carry,
  input  logic [PW-1:0]    in_cor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mcand,
  output logic [WIDTH-1:0] out_mplier,
  output logic [PW-1:0]    out_sum,
  output logic [PW-1:0]    out_carry,
  output logic [PW-1:0]    out_cor
);

  localparam int SH = 2*STAGE_IDX;
  localparam int BW = 2*WIDTH + 3*PW;

  logic [PW-1:0] pp;
  logic          neg;
  logic [PW-1:0] fa_sum;
  logic [PW:0]   cy_chain;
  logic [PW-1:0] cor_next;
  logic [BW-1:0] beat_in;
  logic [BW-1:0] data0;
  logic          valid0;
  logic          push;
  logic          pop;
  logic          carry_msb_unused;

  booth_pp_gen #(
    .WIDTH     (WIDTH),
    .PW        (PW),
    .STAGE_IDX (STAGE_IDX)
  ) u_pp_gen (
    .mcand  (in_mcand),
    .mplier (in_mplier),
    .pp     (pp),
    .neg    (neg)
  );

  // Bit j's carry moves up to position j+1; the carry out of the MSB is dropped.
  assign cy_chain[0] = 1'b0;
  for (genvar j = 0; j < PW; j++) begin : g_fa
    fulladder u_fa (
      .in0   (pp[j]),
      .in1   (in_sum[j]),
      .in2   (in_carry[j]),
      .sum   (fa_sum[j]),
      .carry (cy_chain[j+1])
    );
  end
  assign carry_msb_unused = cy_chain[PW];

  assign cor_next = in_cor | ({{(PW-1){1'b0}}, neg} << SH);
  assign beat_in  = {in_mcand, in_mplier, fa_sum, cy_chain[PW-1:0], cor_next};
  assign pop      = valid0 && out_ready;

`ifdef BOOTH_SKID_EN
  logic [BW-1:0] data1;
  logic          valid1;
  logic          rdy_q;
  logic [BW-1:0] d0_n;
  logic [BW-1:0] d1_n;
  logic          v0_n;
  logic          v1_n;

  assign in_ready = rdy_q;
  assign push     = in_valid && rdy_q;

  // Skid next-state: the skid entry refills the head on pop; a blocked push parks in the skid.
  always_comb begin
    d0_n = data0;
    d1_n = data1;
    v0_n = valid0;
    v1_n = valid1;
    if (valid1) begin
      if (pop) begin
        d0_n = data1;
        v1_n = 1'b0;
      end
    end else if (push) begin
      if (!valid0 || pop) begin
        d0_n = beat_in;
        v0_n = 1'b1;
      end else begin
        d1_n = beat_in;
        v1_n = 1'b1;
      end
    end else if (pop) begin
      v0_n = 1'b0;
    end
  end

  // Buffer registers; in_ready is registered from the next skid occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0  <= '0;
      data1  <= '0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      data0  <= d0_n;
      data1  <= d1_n;
      valid0 <= v0_n;
      valid1 <= v1_n;
      rdy_q  <= !v1_n;
    end
  end
`else
  assign in_ready = !rst && (!valid0 || out_ready);
  assign push     = in_valid && in_ready;

  // Single output register; a push may replace a beat being popped in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0  <= '0;
      valid0 <= 1'b0;
    end else if (push) begin
      data0  <= beat_in;
      valid0 <= 1'b1;
    end else if (pop) begin
      valid0 <= 1'b0;
    end
  end
`endif

  assign out_valid = valid0;
  assign {out_mcand, out_mplier, out_sum, out_carry, out_cor} = data0;

endmodule

// File: tb/tb_booth_csa_row_stage.sv
// Self-checking bench for booth_csa_row_stage: single rows plus a 4-row chain.
module tb_booth_csa_row_stage;

`ifdef BOOTH_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Row A: STAGE_IDX = 0
  logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
  logic [7:0]  a_mcand = 0, a_mplier = 0, a_out_mcand, a_out_mplier;
  logic [15:0] a_sum = 0, a_carry = 0, a_cor = 0, a_out_sum, a_out_carry, a_out_cor;

  // Row B: STAGE_IDX = 1
  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
  logic [7:0]  b_mcand = 0, b_mplier = 0, b_out_mcand, b_out_mplier;
  logic [15:0] b_sum = 0, b_carry = 0, b_cor = 0, b_out_sum, b_out_carry, b_out_cor;

  // Chain of 4 rows
  logic        c_in_valid = 0, c_out_ready = 1;
  logic [7:0]  c_mcand = 0, c_mplier = 0;
  logic        ch_valid [5];
  logic        ch_ready [5];
  logic [7:0]  ch_m [5];
  logic [7:0]  ch_mp [5];
  logic [15:0] ch_s [5];
  logic [15:0] ch_c [5];
  logic [15:0] ch_cor [5];

  assign ch_valid[0] = c_in_valid;
  assign ch_m[0]     = c_mcand;
  assign ch_mp[0]    = c_mplier;
  assign ch_s[0]     = 16'h0;
  assign ch_c[0]     = 16'h0;
  assign ch_cor[0]   = 16'h0;
  assign ch_ready[4] = c_out_ready;

  booth_csa_row_stage #(.WIDTH(8), .PW(16), .STAGE_IDX(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mcand(a_mcand), .in_mplier(a_mplier), .in_sum(a_sum), .in_carry(a_carry), .in_cor(a_cor),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mcand(a_out_mcand), .out_mplier(a_out_mplier),
    .out_sum(a_out_sum), .out_carry(a_out_carry), .out_cor(a_out_cor));

  booth_csa_row_stage #(.WIDTH(8), .PW(16), .STAGE_IDX(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mcand(b_mcand), .in_mplier(b_mplier), .in_sum(b_sum), .in_carry(b_carry), .in_cor(b_cor),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mcand(b_out_mcand), .out_mplier(b_out_mplier),
    .out_sum(b_out_sum), .out_carry(b_out_carry), .out_cor(b_out_cor));

  for (genvar k = 0; k < 4; k++) begin : g_chain
    booth_csa_row_stage #(.WIDTH(8), .PW(16), .STAGE_IDX(k)) u_row (
      .clk(clk), .rst(rst), .in_valid(ch_valid[k]), .in_ready(ch_ready[k]),
      .in_mcand(ch_m[k]), .in_mplier(ch_mp[k]), .in_sum(ch_s[k]), .in_carry(ch_c[k]), .in_cor(ch_cor[k]),
      .out_valid(ch_valid[k+1]), .out_ready(ch_ready[k+1]), .out_mcand(ch_m[k+1]), .out_mplier(ch_mp[k+1]),
      .out_sum(ch_s[k+1]), .out_carry(ch_c[k+1]), .out_cor(ch_cor[k+1]));
  end

  // Reference row: returns {mcand, mplier, sum, carry, cor}.
  function automatic logic [63:0] model_row(input int stage, input logic [7:0] m, input logic [7:0] mp,
                                            input logic [15:0] s, input logic [15:0] c, input logic [15:0] cr);
    logic [8:0]  ext;
    logic [2:0]  t;
    int          d;
    logic [15:0] mag, pp, sm, cy, co;
    ext = {mp, 1'b0};
    t   = ext[2*stage +: 3];
    case (t)
      3'b001, 3'b010: d = 1;
      3'b011:         d = 2;
      3'b100:         d = -2;
      3'b101, 3'b110: d = -1;
      default:        d = 0;
    endcase
    mag = {{8{m[7]}}, m} * 16'((d < 0) ? -d : d);
    pp  = (d < 0) ? ~mag : mag;
    pp  = pp << (2*stage);
    sm  = pp ^ s ^ c;
    cy  = ((pp & s) | (pp & c) | (s & c)) << 1;
    co  = cr | ((d < 0) ? (16'd1 << (2*stage)) : 16'd0);
    return {m, mp, sm, cy, co};
  endfunction

  task automatic test_reset();
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", a_in_ready); end
    n_cmp++; if ({a_out_sum, a_out_carry, a_out_cor} !== 48'h0) begin n_fail++;
      $display("FAIL reset_data got %h exp 0", {a_out_sum, a_out_carry, a_out_cor}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b exp 1", a_in_ready); end
  endtask

  task automatic test_neg_digit();
    @(negedge clk);
    a_in_valid = 1; a_mcand = 8'd5; a_mplier = 8'h03; a_sum = 0; a_carry = 0; a_cor = 0; a_out_ready = 1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL neg_in_ready got %b exp 1", a_in_ready); end
    @(negedge clk); a_in_valid = 0; #1;
    n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL neg_valid got %b exp 1", a_out_valid); end
    n_cmp++; if (a_out_sum !== 16'hFFFA) begin n_fail++; $display("FAIL neg_sum got %h exp fffa", a_out_sum); end
    n_cmp++; if (a_out_carry !== 16'h0000) begin n_fail++; $display("FAIL neg_carry got %h exp 0000", a_out_carry); end
    n_cmp++; if (a_out_cor !== 16'h0001) begin n_fail++; $display("FAIL neg_cor got %h exp 0001", a_out_cor); end
    n_cmp++; if (16'(a_out_sum + a_out_carry + a_out_cor) !== 16'hFFFB) begin n_fail++;
      $display("FAIL neg_total got %h exp fffb", 16'(a_out_sum + a_out_carry + a_out_cor)); end
  endtask

  task automatic test_pos2_digit();
    @(negedge clk);
    b_in_valid = 1; b_mcand = 8'd3; b_mplier = 8'h06; b_sum = 16'h0003; b_carry = 16'h0004; b_cor = 0;
    @(negedge clk); b_in_valid = 0; #1;
    n_cmp++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL pos2_valid got %b exp 1", b_out_valid); end
    n_cmp++; if (16'(b_out_sum + b_out_carry + b_out_cor) !== 16'h001F) begin n_fail++;
      $display("FAIL pos2_total got %h exp 001f", 16'(b_out_sum + b_out_carry + b_out_cor)); end
    n_cmp++; if (b_out_cor !== 16'h0000) begin n_fail++; $display("FAIL pos2_cor got %h exp 0000", b_out_cor); end
  endtask

  task automatic test_zero_digit();
    logic [7:0]  mps [2];
    logic [15:0] s, c, cr;
    mps[0] = 8'h00; mps[1] = 8'hFF;
    for (int p = 0; p < 2; p++) begin
      s = 16'($urandom); c = 16'($urandom); cr = 16'($urandom);
      @(negedge clk);
      b_in_valid = 1; b_mcand = 8'($urandom); b_mplier = mps[p]; b_sum = s; b_carry = c; b_cor = cr;
      @(negedge clk); b_in_valid = 0; #1;
      n_cmp++; if (b_out_sum !== (s ^ c)) begin n_fail++; $display("FAIL zero_sum got %h exp %h", b_out_sum, s ^ c); end
      n_cmp++; if (b_out_carry !== 16'((s & c) << 1)) begin n_fail++;
        $display("FAIL zero_carry got %h exp %h", b_out_carry, 16'((s & c) << 1)); end
      n_cmp++; if (b_out_cor !== cr) begin n_fail++; $display("FAIL zero_cor got %h exp %h", b_out_cor, cr); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_q [$];
    logic [63:0] held, got_v, exp_v;
    logic        held_v = 0;
    int          sent = 0, got = 0;
    repeat (2) @(negedge clk);
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge clk);
      a_out_ready = (cyc >= 5);
      if (sent < 3) begin
        a_in_valid = 1; a_mcand = 8'(8'h91 + 8'(sent * 7)); a_mplier = 8'(8'h35 + 8'(sent * 13));
        a_sum = 16'(16'h1234 * (sent + 1)); a_carry = 16'(16'h0F0F << sent); a_cor = 16'h0;
      end else begin
        a_in_valid = 0;
      end
      #1;
      got_v = {a_out_mcand, a_out_mplier, a_out_sum, a_out_carry, a_out_cor};
      if (cyc == 4) begin
        n_cmp++; if (sent != EXP_ACC) begin n_fail++; $display("FAIL bp_accepted got %0d exp %0d", sent, EXP_ACC); end
        n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", a_in_ready); end
      end
      if (held_v) begin
        n_cmp++; if (got_v !== held) begin n_fail++; $display("FAIL bp_stable got %h exp %h", got_v, held); end
      end
      held_v = a_out_valid && !a_out_ready;
      held   = got_v;
      if (a_out_valid && a_out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra_beat got %h exp none", got_v); end
        else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v) begin n_fail++; $display("FAIL bp_data got %h exp %h", got_v, exp_v); end
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        exp_q.push_back(model_row(0, a_mcand, a_mplier, a_sum, a_carry, a_cor));
        sent++;
      end
    end
    n_cmp++; if (got != 3) begin n_fail++; $display("FAIL bp_drain got %0d exp 3", got); end
    a_in_valid = 0; a_out_ready = 1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_out_ready = 0; a_in_valid = 1; a_mcand = 8'h77; a_mplier = 8'h5A; a_sum = 16'hABCD; a_carry = 16'h1111; a_cor = 0;
    repeat (4) @(negedge clk);
    a_in_valid = 0; #1;
    n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_full got %b exp 1", a_out_valid); end
    #1 rst = 1'b1; #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", a_out_valid); end
    n_cmp++; if ({a_out_mcand, a_out_mplier, a_out_sum, a_out_carry, a_out_cor} !== 64'h0) begin n_fail++;
      $display("FAIL rmid_data got %h exp 0", {a_out_mcand, a_out_mplier, a_out_sum, a_out_carry, a_out_cor}); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready got %b exp 0", a_in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; a_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale got %b exp 0", a_out_valid); end
    end
  endtask

  task automatic test_chain();
    logic [31:0]        exp_q [$];
    logic [31:0]        exp_v;
    logic [15:0]        tot;
    logic signed [15:0] prod;
    int                 sent = 0, got = 0;
    logic [7:0]         ca, cb;
    ca = 8'($urandom); cb = 8'($urandom);
    repeat (3) @(negedge clk);
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      c_out_ready = 1'($urandom_range(0, 1));
      c_in_valid  = (sent < 1000);
      c_mcand = ca; c_mplier = cb;
      #1;
      if (cyc >= 10 && sent < 1000 && c_out_ready) begin
        n_cmp++; if (ch_valid[4] !== 1'b1) begin n_fail++; $display("FAIL chain_rate cyc %0d got %b exp 1", cyc, ch_valid[4]); end
      end
      if (ch_valid[4] && c_out_ready) begin
        tot = 16'(ch_s[4] + ch_c[4] + ch_cor[4]);
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL chain_extra got %h exp none", tot); end
        else begin
          exp_v = exp_q.pop_front();
          if ({ch_m[4], ch_mp[4], tot} !== exp_v) begin n_fail++;
            $display("FAIL chain_product got %h exp %h", {ch_m[4], ch_mp[4], tot}, exp_v); end
        end
        got++;
      end
      if (c_in_valid && ch_ready[0]) begin
        prod = $signed(ca) * $signed(cb);
        exp_q.push_back({ca, cb, prod});
        sent++;
        ca = 8'($urandom); cb = 8'($urandom);
      end
    end
    n_cmp++; if (got != 1000) begin n_fail++; $display("FAIL chain_count got %0d exp 1000", got); end
    c_in_valid = 0; c_out_ready = 1;
  endtask

  initial begin
    test_reset();
    test_neg_digit();
    test_pos2_digit();
    test_zero_digit();
    test_backpressure();
    test_reset_mid();
    test_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
